// File: rtl/dac_fifo_reader.sv
// Read side of the DAC sample FIFO: drains one 32-bit sample per DIV clocks,
// converts it to offset-binary, and drives the DAC data bus and sample clock.
module dac_fifo_reader #(
  parameter int DIV       = 8,
  parameter int DAC_W     = 14,
  parameter int CNT_W     = 10,
  parameter int PREFILL   = 4,
  parameter int UNDER_MAX = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             fifo_empty,
  input  logic [CNT_W-1:0] fifo_count,
  input  logic [31:0]      fifo_rd_data,
  output logic             fifo_rd_en,
  output logic [DAC_W-1:0] dac_data,
  output logic             dac_clk,
  output logic             dac_valid,
  output logic             underrun,
  output logic [15:0]      underrun_cnt,
  output logic [1:0]       state_o
);

  localparam int PH_W = $clog2(DIV);
  localparam int UC_W = $clog2(UNDER_MAX + 1);
  localparam logic [DAC_W-1:0] MIDSCALE = {1'b1, {(DAC_W-1){1'b0}}};
  localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(DIV - 1);
  localparam logic [PH_W-1:0]  PH_HALF  = PH_W'(DIV / 2);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRE     = 2'd1,
    RUN     = 2'd2
  } state_t;

  state_t            state_reg, state_next;
  logic [PH_W-1:0]   ph_reg;
  logic [UC_W-1:0]   consec_reg;
  logic              data_due_reg;
  logic              slot, starve, run_stay, clear_under;
  logic [DAC_W-1:0]  code;
  logic              unused_low_bits;

  // Truncate to the top DAC_W bits and flip the sign bit (two's complement -> offset binary).
  genvar gi;
  generate
    for (gi = 0; gi < DAC_W; gi++) begin : g_conv
      if (gi == DAC_W - 1) begin : g_msb
        assign code[gi] = ~fifo_rd_data[32 - DAC_W + gi];
      end else begin : g_bit
        assign code[gi] = fifo_rd_data[32 - DAC_W + gi];
      end
    end
  endgenerate

  assign unused_low_bits = ^fifo_rd_data[31-DAC_W:0];

  always_comb begin
    slot        = (state_reg == RUN) && enable && (ph_reg == '0);
    starve      = slot && fifo_empty;
    state_next  = state_reg;
    case (state_reg)
      IDLE:    if (enable) state_next = PRE;
      PRE:     if (enable && (fifo_count >= CNT_W'(PREFILL))) state_next = RUN;
      RUN:     if (starve && (consec_reg >= UC_W'(UNDER_MAX - 1))) state_next = PRE;
      default: state_next = IDLE;
    endcase
    if (!enable) state_next = IDLE;
    run_stay    = (state_reg == RUN) && (state_next == RUN);
    clear_under = (state_reg == IDLE) && (state_next == PRE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      ph_reg       <= '0;
      consec_reg   <= '0;
      data_due_reg <= 1'b0;
      fifo_rd_en   <= 1'b0;
      dac_data     <= MIDSCALE;
      dac_clk      <= 1'b0;
      dac_valid    <= 1'b0;
      underrun     <= 1'b0;
      underrun_cnt <= '0;
    end else begin
      state_reg <= state_next;

      if (run_stay)
        ph_reg <= (ph_reg == PH_LAST) ? '0 : ph_reg + PH_W'(1);
      else
        ph_reg <= '0;

      fifo_rd_en   <= slot && !fifo_empty;
      // Read data is valid the cycle after the strobe; drop it if playback stops meanwhile.
      data_due_reg <= fifo_rd_en && run_stay;
      dac_valid    <= data_due_reg && run_stay;
      dac_clk      <= run_stay && (ph_reg >= PH_HALF);

      if (state_next == IDLE)
        dac_data <= MIDSCALE;
      else if (data_due_reg && run_stay)
        dac_data <= code;

      if (state_reg != RUN)
        consec_reg <= '0;
      else if (starve)
        consec_reg <= consec_reg + UC_W'(1);
      else if (data_due_reg && run_stay)
        consec_reg <= '0;

      if (clear_under) begin
        underrun     <= 1'b0;
        underrun_cnt <= '0;
      end else if (starve) begin
        underrun <= 1'b1;
        if (underrun_cnt != 16'hFFFF)
          underrun_cnt <= underrun_cnt + 16'd1;
      end
    end
  end

  assign state_o = state_reg;

endmodule

// File: doc/dac_fifo_reader.md
Name: dac_fifo_reader

Overview:
Read side of the DAC sample FIFO. The filter chain writes 32-bit filtered samples into this FIFO; this block drains it at a fixed sample rate derived from clk.
- Each sample is converted from signed two's complement to offset-binary DAC code.
- The block drives the DAC data bus and the DAC sample clock.
- It handles prefill, underrun and enable/disable. Underrun status is exposed for capture by the on-chip analyzer.

Parameters:
DIV, 8, clk cycles per DAC sample; must be >= 8 and even.
DAC_W, 14, DAC data width; must be 1..31.
CNT_W, 10, width of the FIFO fill-level input.
PREFILL, 4, FIFO words required before playback starts (or restarts).
UNDER_MAX, 4, consecutive underruns that force a return to PREFILL.

Ports:
clk  in  1  system clock; all logic is on the rising edge.
rst  in  1  synchronous, active-high reset.
enable  in  1  playback enable (level).
fifo_empty  in  1  FIFO empty flag.
fifo_count  in  CNT_W  FIFO fill level in words.
fifo_rd_data  in  32  FIFO read data; valid 1 cycle after fifo_rd_en.
fifo_rd_en  out  1  FIFO read strobe; registered; one cycle per sample.
dac_data  out  DAC_W  offset-binary DAC code; registered.
dac_clk  out  1  DAC sample clock; registered.
dac_valid  out  1  one-cycle pulse when dac_data updates with a new sample.
underrun  out  1  sticky underrun flag.
underrun_cnt  out  16  saturating count of underrun events.
state_o  out  2  current state: 0 IDLE, 1 PREFILL, 2 RUN.

Behaviour:
- Reset values:
  - state = IDLE; all counters 0.
  - fifo_rd_en = 0, dac_valid = 0, dac_clk = 0, underrun = 0, underrun_cnt = 0.
  - dac_data = midscale, i.e. 1 followed by DAC_W-1 zeros (0x2000 for DAC_W=14).
- State transitions (evaluated every cycle):
  - IDLE -> PREFILL when enable = 1.
  - PREFILL -> RUN when enable = 1 and fifo_count >= PREFILL.
  - RUN -> PREFILL when the consecutive-underrun count reaches UNDER_MAX.
  - Any state -> IDLE on the cycle after enable = 0. In that cycle dac_data returns to midscale and dac_clk goes to 0.
- Underrun clearing: underrun and underrun_cnt are cleared only by rst or by an IDLE -> PREFILL transition.
- Phase counter (ph):
  - Counts 0..DIV-1 and wraps, only while in RUN.
  - Forced to 0 on entry to RUN and whenever not in RUN.
  - The first RUN cycle has ph = 0.
- Sample slot, per period:
  - At ph = 0, if fifo_empty = 0: fifo_rd_en = 1 for that cycle only.
  - At ph = 1: fifo_rd_data is sampled.
  - At ph = 2: dac_data is updated, dac_valid = 1 for one cycle, and the consecutive-underrun count resets to 0.
- Empty at the slot: at ph = 0 with fifo_empty = 1:
  - No read is issued and dac_data holds its last value.
  - underrun is set; underrun_cnt increments and saturates at 0xFFFF.
  - The consecutive-underrun count increments.
  - A FIFO that becomes non-empty mid-period is not read until the next ph = 0.
- dac_clk = 1 when ph >= DIV/2 (registered), 0 otherwise. The rising edge therefore comes >= 2 clk after dac_data changes.
- Conversion: code = fifo_rd_data[31:32-DAC_W] with its MSB inverted. Truncation only; no rounding, no saturation.
  - 0x7FFF_FFFF -> 0x3FFF.
  - 0x8000_0000 -> 0x0000.
  - 0x0000_0000 -> 0x2000.
- Exactly one read per DIV cycles, so throughput is one sample per DIV clk.
- Reset mid-operation: all outputs take their reset values on the next edge. A read issued in the reset cycle is discarded.
- enable deasserted at ph = 0 or 1: any pending read data is discarded and the word is lost. This is accepted; upstream flushes the FIFO on re-enable.

Test Plan:
- Reset check: rst for 3 cycles with enable = 1 -> state_o = 0, dac_data = 0x2000, fifo_rd_en = 0, underrun = 0.
- Prefill: enable = 1 with fifo_count = 3 for 20 cycles -> state_o stays 1 and fifo_rd_en stays 0. Set fifo_count = 4 -> state_o = 2 next cycle, then fifo_rd_en pulses every 8 cycles.
- Conversion and timing: FIFO model loaded with 0x7FFF_0000, 0x8000_0000, 0x0000_0000.
  - dac_data sequence 0x3FFF, 0x0000, 0x2000.
  - Each update lands 2 cycles after its fifo_rd_en, with dac_valid pulsed.
  - dac_clk rises 2 cycles after each update.
- Single underrun: fifo_empty = 1 at one ph = 0 slot -> no fifo_rd_en, dac_data holds, underrun = 1, underrun_cnt = 1, state stays RUN.
- Sustained underrun: 4 consecutive empty slots -> state_o = 1, underrun_cnt = 4. Refill to 4 words -> RUN resumes at ph = 0.
- Disable: enable = 0 mid-period -> state_o = 0 and dac_data = 0x2000 next cycle, with no further fifo_rd_en. Re-enable -> underrun_cnt = 0.
